ex_mem_req: RTL and testbench



---
 rtl/ex_mem_req_pkg.sv | 16 +
 rtl/ex_mem_req_store_align.sv | 31 +++
 rtl/ex_mem_req.sv | 163 ++++++++++++++++
 tb/tb_ex_mem_req.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_req_pkg.sv
// Shared constants for the EX-stage data-memory request issuer.
package ex_mem_req_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned MAX_OUTSTANDING_DEF = 1;

endpackage

// File: rtl/ex_mem_req_store_align.sv
// Byte-lane strobe and replicated write data for SRAM-like stores.
module ex_mem_req_store_align
    import ex_mem_req_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_out
);

    always_comb begin
        wstrb     = '0;
        wdata_out = wdata;
        case (size)
            SIZE_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_out = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_out = {2{wdata[15:0]}};
            end
            SIZE_W: wstrb = 4'hf;
            default: wstrb = '0;
        endcase
        if (!we) wstrb = '0;
    end

endmodule

// File: rtl/ex_mem_req.sv
// EX-stage data-memory request issuer: one request per load/store, holds req
// until addr_ok, and masks data_ok responses owned by flushed instructions.
module ex_mem_req
    import ex_mem_req_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int unsigned DISCARD_W       = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic        mem_op,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        except_in,
    input  logic        flush,
    input  logic        mem_allow_in,
    output logic        ex_ready_go,
    output logic        ale,
    output logic        wait_data_ok,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        data_ok_to_mem
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_OS = CNT_W'(MAX_OUTSTANDING);

    state_t                 state;
    logic                   flush_seen;
    logic [CNT_W-1:0]       out_cnt;
    logic [DISCARD_W-1:0]   discard_cnt;

    logic        lat_wr;
    logic [1:0]  lat_size;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        is_mem, ale_raw, issue, accept;
    logic        disc_inc, disc_dec, out_inc, out_dec;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;

    ex_mem_req_store_align u_store_align (
        .we        (mem_we),
        .size      (mem_size),
        .addr_lo   (mem_addr[1:0]),
        .wdata     (mem_wdata),
        .wstrb     (al_wstrb),
        .wdata_out (al_wdata)
    );

    // resetn gates the combinational paths so every output except ex_ready_go is 0 in reset
    assign is_mem  = in_valid & mem_op;
    assign ale_raw = is_mem & (((mem_size == SIZE_H) & mem_addr[0]) |
                               ((mem_size == SIZE_W) & (mem_addr[1:0] != 2'b00)));
    assign ale     = resetn & ale_raw;
    assign issue   = resetn & is_mem & ~ale_raw & ~except_in & ~flush &
                     (out_cnt < MAX_OS) & (discard_cnt == '0);

    assign data_sram_req  = ((state == ST_IDLE) & issue) | (state == ST_REQ);
    assign accept         = data_sram_req & data_sram_addr_ok;
    assign wait_data_ok   = accept | (state == ST_DONE);
    assign ex_ready_go    = ~is_mem | ale_raw | except_in | accept | (state == ST_DONE);
    assign data_ok_to_mem = resetn & data_sram_data_ok & (discard_cnt == '0);

    always_comb begin
        data_sram_wr    = 1'b0;
        data_sram_size  = '0;
        data_sram_wstrb = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (state == ST_REQ) begin
            data_sram_wr    = lat_wr;
            data_sram_size  = lat_size;
            data_sram_wstrb = lat_wstrb;
            data_sram_addr  = lat_addr;
            data_sram_wdata = lat_wdata;
        end else if (data_sram_req) begin
            data_sram_wr    = mem_we;
            data_sram_size  = mem_size;
            data_sram_wstrb = al_wstrb;
            data_sram_addr  = mem_addr;
            data_sram_wdata = al_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            flush_seen <= 1'b0;
            lat_wr     <= 1'b0;
            lat_size   <= '0;
            lat_wstrb  <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        lat_wr     <= mem_we;
                        lat_size   <= mem_size;
                        lat_wstrb  <= al_wstrb;
                        lat_addr   <= mem_addr;
                        lat_wdata  <= al_wdata;
                        flush_seen <= 1'b0;
                        if (data_sram_addr_ok)
                            state <= mem_allow_in ? ST_IDLE : ST_DONE;
                        else
                            state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A flush while waiting cannot retract req; remember it so the response is discarded
                    if (data_sram_addr_ok) begin
                        state      <= (mem_allow_in | flush | flush_seen) ? ST_IDLE : ST_DONE;
                        flush_seen <= 1'b0;
                    end else if (flush) begin
                        flush_seen <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (flush | mem_allow_in) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_inc  = accept;
    assign out_dec  = data_sram_data_ok;
    assign disc_inc = ((state == ST_REQ) & data_sram_addr_ok & (flush | flush_seen)) |
                      ((state == ST_DONE) & flush);
    assign disc_dec = data_sram_data_ok & (discard_cnt != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_cnt     <= '0;
            discard_cnt <= '0;
        end else begin
            case ({out_inc, out_dec})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
            case ({disc_inc, disc_dec})
                2'b10:   discard_cnt <= discard_cnt + DISCARD_W'(1);
                2'b01:   discard_cnt <= discard_cnt - DISCARD_W'(1);
                default: discard_cnt <= discard_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_req.sv
// Scoreboard bench for ex_mem_req: expected requests and data_ok masking are
// queued by the stimulus and checked by a negedge monitor.
module tb_ex_mem_req;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } pl_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, mem_op, mem_we, except_in, flush, mem_allow_in;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        ex_ready_go, ale, wait_data_ok;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok, data_ok_to_mem;

    int tests = 0;
    int fails = 0;
    pl_t  pq[$];
    logic okq[$];

    always #5 clk = ~clk;

    ex_mem_req #(.MAX_OUTSTANDING(1), .DISCARD_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .mem_op(mem_op), .mem_we(mem_we),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .except_in(except_in), .flush(flush), .mem_allow_in(mem_allow_in),
        .ex_ready_go(ex_ready_go), .ale(ale), .wait_data_ok(wait_data_ok),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_ok_to_mem(data_ok_to_mem)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_op(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        in_valid  = 1'b1;
        mem_op    = 1'b1;
        mem_we    = we;
        mem_size  = sz;
        mem_addr  = a;
        mem_wdata = wd;
    endtask

    task automatic ret_data(input logic exp_to_mem);
        data_sram_data_ok = 1'b1;
        okq.push_back(exp_to_mem);
        at_neg();
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands off a request or a response arrives
    always @(negedge clk) begin
        if (data_sram_req && data_sram_addr_ok) begin
            if (pq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_req: got addr %h expected no request", data_sram_addr);
            end else begin
                pl_t e;
                e = pq.pop_front();
                chk("req_wr",    32'(data_sram_wr),    32'(e.wr));
                chk("req_size",  32'(data_sram_size),  32'(e.size));
                chk("req_wstrb", 32'(data_sram_wstrb), 32'(e.wstrb));
                chk("req_addr",  data_sram_addr,       e.addr);
                chk("req_wdata", data_sram_wdata,      e.wdata);
            end
        end
        if (data_sram_data_ok) begin
            if (okq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_data_ok: got data_ok with no expectation queued");
            end else begin
                chk("data_ok_to_mem", 32'(data_ok_to_mem), 32'(okq.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] st_addr  [3];
        logic [1:0]  st_size  [3];
        logic [31:0] st_wdata [3];
        logic [3:0]  st_wstrb [3];
        logic [31:0] st_owd   [3];
        st_addr  = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1004};
        st_size  = '{2'd0, 2'd1, 2'd2};
        st_wdata = '{32'h1234_5678, 32'hAABB_CCDD, 32'hCAFE_F00D};
        st_wstrb = '{4'b1000, 4'b1100, 4'b1111};
        st_owd   = '{32'h7878_7878, 32'hCCDD_CCDD, 32'hCAFE_F00D};

        resetn = 1'b0;
        in_valid = 0; mem_op = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
        except_in = 0; flush = 0; mem_allow_in = 0;
        data_sram_addr_ok = 0; data_sram_data_ok = 0;
        #2;
        chk("rst_req",   32'(data_sram_req),   0);
        chk("rst_wait",  32'(wait_data_ok),    0);
        chk("rst_ale",   32'(ale),             0);
        chk("rst_wstrb", 32'(data_sram_wstrb), 0);
        chk("rst_addr",  data_sram_addr,       0);
        chk("rst_ready", 32'(ex_ready_go),     1);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // non-memory instruction passes straight through
        in_valid = 1'b1; mem_op = 1'b0;
        at_neg();
        chk("nonmem_ready", 32'(ex_ready_go),   1);
        chk("nonmem_req",   32'(data_sram_req), 0);
        tick();

        // stores accepted in the issue cycle
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, st_size[i], st_addr[i], st_wdata[i]);
            data_sram_addr_ok = 1'b1; mem_allow_in = 1'b1;
            pq.push_back('{1'b1, st_size[i], st_wstrb[i], st_addr[i], st_owd[i]});
            at_neg();
            chk("store_ready", 32'(ex_ready_go),  1);
            chk("store_wait",  32'(wait_data_ok), 1);
            tick();
            in_valid = 1'b0; data_sram_addr_ok = 1'b0; mem_allow_in = 1'b0;
            ret_data(1'b1);
        end

        // load word with addr_ok three cycles late, then one cycle in DONE
        set_op(1'b0, 2'd2, 32'h0000_2000, 32'h0);
        pq.push_back('{1'b0, 2'd2, 4'b0000, 32'h0000_2000, 32'h0});
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("lw_hold_req",   32'(data_sram_req),   1);
            chk("lw_hold_ready", 32'(ex_ready_go),     0);
            chk("lw_hold_wait",  32'(wait_data_ok),    0);
            chk("lw_hold_addr",  data_sram_addr,       32'h0000_2000);
            chk("lw_hold_size",  32'(data_sram_size),  2);
            chk("lw_hold_wstrb", 32'(data_sram_wstrb), 0);
            tick();
        end
        data_sram_addr_ok = 1'b1;
        at_neg();
        chk("lw_acc_ready", 32'(ex_ready_go),  1);
        chk("lw_acc_wait",  32'(wait_data_ok), 1);
        tick();
        data_sram_addr_ok = 1'b0; mem_allow_in = 1'b1;
        at_neg();
        chk("lw_done_req",   32'(data_sram_req), 0);
        chk("lw_done_ready", 32'(ex_ready_go),   1);
        chk("lw_done_wait",  32'(wait_data_ok),  1);
        tick();
        in_valid = 1'b0; mem_allow_in = 1'b0;
        ret_data(1'b1);

        // misaligned half load
        set_op(1'b0, 2'd1, 32'h0000_2001, 32'h0);
        at_neg();
        chk("ale_ale",   32'(ale),           1);
        chk("ale_req",   32'(data_sram_req), 0);
        chk("ale_ready", 32'(ex_ready_go),   1);
        chk("ale_wait",  32'(wait_data_ok),  0);
        tick();
        in_valid = 1'b0;

        // flush while REQ pending: request still completes, its response is discarded
        set_op(1'b0, 2'd2, 32'h0000_3000, 32'h0);
        pq.push_back('{1'b0, 2'd2, 4'b0000, 32'h0000_3000, 32'h0});
        at_neg(); tick();
        flush = 1'b1;
        at_neg();
        chk("flreq_c2_req", 32'(data_sram_req), 1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        at_neg();
        chk("flreq_c3_req", 32'(data_sram_req), 1);
        tick();
        data_sram_addr_ok = 1'b1;
        at_neg();
        chk("flreq_c4_req", 32'(data_sram_req), 1);
        tick();
        data_sram_addr_ok = 1'b0;
        set_op(1'b0, 2'd2, 32'h0000_4000, 32'h0);
        mem_allow_in = 1'b1;
        data_sram_data_ok = 1'b1;
        okq.push_back(1'b0);
        at_neg();
        chk("flreq_blocked_req",   32'(data_sram_req), 0);
        chk("flreq_blocked_ready", 32'(ex_ready_go),   0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_addr_ok = 1'b1;
        pq.push_back('{1'b0, 2'd2, 4'b0000, 32'h0000_4000, 32'h0});
        at_neg();
        chk("flreq_next_req", 32'(data_sram_req), 1);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; mem_allow_in = 1'b0;
        ret_data(1'b1);

        // flush in DONE: next load waits until the stale response is absorbed
        set_op(1'b0, 2'd2, 32'h0000_5000, 32'h0);
        data_sram_addr_ok = 1'b1;
        pq.push_back('{1'b0, 2'd2, 4'b0000, 32'h0000_5000, 32'h0});
        at_neg(); tick();
        data_sram_addr_ok = 1'b0; flush = 1'b1;
        at_neg();
        chk("fldone_req",  32'(data_sram_req), 0);
        chk("fldone_wait", 32'(wait_data_ok),  1);
        tick();
        flush = 1'b0;
        set_op(1'b0, 2'd2, 32'h0000_6000, 32'h0);
        mem_allow_in = 1'b1; data_sram_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("fldone_blocked_req",   32'(data_sram_req), 0);
            chk("fldone_blocked_ready", 32'(ex_ready_go),   0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        okq.push_back(1'b0);
        at_neg();
        chk("fldone_drain_req", 32'(data_sram_req), 0);
        tick();
        data_sram_data_ok = 1'b0;
        pq.push_back('{1'b0, 2'd2, 4'b0000, 32'h0000_6000, 32'h0});
        at_neg();
        chk("fldone_next_req", 32'(data_sram_req), 1);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; mem_allow_in = 1'b0;
        ret_data(1'b1);

        // outstanding limit: a second load waits for the first response
        set_op(1'b0, 2'd2, 32'h0000_9000, 32'h0);
        data_sram_addr_ok = 1'b1; mem_allow_in = 1'b1;
        pq.push_back('{1'b0, 2'd2, 4'b0000, 32'h0000_9000, 32'h0});
        at_neg(); tick();
        set_op(1'b0, 2'd2, 32'h0000_9004, 32'h0);
        at_neg();
        chk("outlim_req", 32'(data_sram_req), 0);
        tick();
        data_sram_data_ok = 1'b1;
        okq.push_back(1'b1);
        at_neg();
        chk("outlim_dok_req", 32'(data_sram_req), 0);
        tick();
        data_sram_data_ok = 1'b0;
        pq.push_back('{1'b0, 2'd2, 4'b0000, 32'h0000_9004, 32'h0});
        at_neg();
        chk("outlim_next_req", 32'(data_sram_req), 1);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; mem_allow_in = 1'b0;
        ret_data(1'b1);

        // reset in the middle of REQ
        set_op(1'b0, 2'd2, 32'h0000_7000, 32'h0);
        at_neg(); tick();
        chk("rstreq_pre_req", 32'(data_sram_req), 1);
        resetn = 1'b0;
        #1;
        chk("rstreq_req",  32'(data_sram_req), 0);
        chk("rstreq_wait", 32'(wait_data_ok),  0);
        tick();
        resetn = 1'b1; in_valid = 1'b0;
        tick();
        set_op(1'b0, 2'd2, 32'h0000_8000, 32'h0);
        data_sram_addr_ok = 1'b1; mem_allow_in = 1'b1;
        pq.push_back('{1'b0, 2'd2, 4'b0000, 32'h0000_8000, 32'h0});
        at_neg();
        chk("rstreq_next_req", 32'(data_sram_req), 1);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; mem_allow_in = 1'b0;
        ret_data(1'b1);

        tick();
        chk("payload_q_left", pq.size(), 0);
        chk("dataok_q_left",  okq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
